// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types and constants for the CPU/DMA memory port arbiter
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   // Transaction sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CAPT  = 3'd3,
      ST_RESP  = 3'd4
   } arb_state_t;

   // Grant encoding
   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DMA = 1'b1;

   // Width of the latency and starvation counters
   localparam int CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/arb_priority_sel.sv
`default_nettype none
// ============================================================================
//  Module   : arb_priority_sel
//  Brief    : CPU-priority winner select with a saturating DMA starvation
//             counter that forces a DMA grant after STARVE_MAX CPU wins
//  Revision : 1.0  initial release
// ============================================================================
module arb_priority_sel
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
)(
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic arb_en,       // high in the cycle a grant decision is taken
   output logic grant_valid,
   output logic grant_sel
);

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] r_starve_cnt;

   // Winner select: CPU by default, DMA when alone or when it has starved
   always_comb begin
      grant_valid = cpu_req | dma_req;
      grant_sel   = GNT_CPU;
      if (dma_req && (!cpu_req || (r_starve_cnt == STARVE_LIM))) begin
         grant_sel = GNT_DMA;
      end
   end

   // Starvation counter: counts CPU wins over a pending DMA, clears otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
      end else if (arb_en) begin
         if (!dma_req || (grant_sel == GNT_DMA)) begin
            r_starve_cnt <= '0;
         end else if (r_starve_cnt != STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one single-port memory between the CPU and a DMA/debug
//             loader; each access runs issue -> latency -> capture -> response
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ready,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic              r_grant;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_lat_cnt;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dma_rdata;
   logic              w_arb_en;
   logic              w_gnt_valid;
   logic              w_gnt_sel;
   logic              w_issue;
   logic              w_resp;

   assign w_arb_en = (r_state == ST_IDLE);

   arb_priority_sel #(
      .STARVE_MAX (STARVE_MAX)
   ) u_sel (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_req     (cpu_req),
      .dma_req     (dma_req),
      .arb_en      (w_arb_en),
      .grant_valid (w_gnt_valid),
      .grant_sel   (w_gnt_sel)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: writes skip the latency phase, reads wait MEM_LAT-1 cycles
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_gnt_valid) w_next_state = ST_ISSUE;
         ST_ISSUE: begin
            if (r_we)              w_next_state = ST_RESP;
            else if (MEM_LAT == 1) w_next_state = ST_CAPT;
            else                   w_next_state = ST_WAIT;
         end
         // Counter reaches zero on this decrement -> capture next cycle
         ST_WAIT:  if (r_lat_cnt == CNT_W'(1)) w_next_state = ST_CAPT;
         ST_CAPT:  w_next_state = ST_RESP;
         ST_RESP:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Request latch in IDLE, latency countdown, and read-data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant     <= GNT_CPU;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_lat_cnt   <= '0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_valid) begin
                  r_grant <= w_gnt_sel;
                  if (w_gnt_sel == GNT_DMA) begin
                     r_we    <= dma_we;
                     r_addr  <= dma_addr;
                     r_wdata <= dma_wdata;
                  end else begin
                     r_we    <= cpu_we;
                     r_addr  <= cpu_addr;
                     r_wdata <= cpu_wdata;
                  end
               end
            end
            ST_ISSUE: if (!r_we) r_lat_cnt <= LAT_LOAD;
            ST_WAIT:  r_lat_cnt <= r_lat_cnt - CNT_W'(1);
            ST_CAPT: begin
               if (r_grant == GNT_DMA) r_dma_rdata <= mem_rdata;
               else                    r_cpu_rdata <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; memory bus is quiet outside ISSUE
   always_comb begin
      w_issue   = (r_state == ST_ISSUE);
      w_resp    = (r_state == ST_RESP);
      mem_en    = w_issue;
      mem_we    = w_issue & r_we;
      mem_addr  = w_issue ? r_addr  : '0;
      mem_wdata = w_issue ? r_wdata : '0;
      cpu_ready = w_resp & (r_grant == GNT_CPU);
      dma_ready = w_resp & (r_grant == GNT_DMA);
   end

   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench for mem_port_arbiter
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam logic [31:0] POISON = 32'hBAD0_BAD0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic        cpu_ready, dma_ready, mem_en, mem_we;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

   // Second instance built with MEM_LAT=1 (DMA port exercised only)
   logic        d1_cpu_req, d1_cpu_we, d1_dma_req, d1_dma_we;
   logic [31:0] d1_cpu_addr, d1_cpu_wdata, d1_dma_addr, d1_dma_wdata;
   logic        d1_cpu_ready, d1_dma_ready, d1_mem_en, d1_mem_we;
   logic [31:0] d1_cpu_rdata, d1_dma_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ready(dma_ready), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(d1_cpu_req), .cpu_we(d1_cpu_we), .cpu_addr(d1_cpu_addr), .cpu_wdata(d1_cpu_wdata),
      .cpu_ready(d1_cpu_ready), .cpu_rdata(d1_cpu_rdata),
      .dma_req(d1_dma_req), .dma_we(d1_dma_we), .dma_addr(d1_dma_addr), .dma_wdata(d1_dma_wdata),
      .dma_ready(d1_dma_ready), .dma_rdata(d1_dma_rdata),
      .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
      .mem_rdata(d1_mem_rdata)
   );

   // Memory model, 2-cycle read latency; poison outside the valid cycle
   logic [31:0] mem [0:15];
   logic [31:0] rd_pipe0, rd_pipe1, d1_rd_q;
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0]  <= 32'h1111_1111;
         mem[1]  <= 32'h2222_2222;
         mem[4]  <= 32'hDEAD_BEEF;
         mem[12] <= 32'hCAFE_F00D;
         rd_pipe0 <= POISON;
         rd_pipe1 <= POISON;
      end else begin
         if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;
         rd_pipe0 <= (mem_en && !mem_we) ? mem[mem_addr[5:2]] : POISON;
         rd_pipe1 <= rd_pipe0;
      end
   end
   assign mem_rdata = rd_pipe1;

   // Memory model, 1-cycle read latency; data is a pattern of the address
   always @(posedge clk) begin
      d1_rd_q <= (d1_mem_en && !d1_mem_we) ? (32'h5A5A_0000 | d1_mem_addr) : POISON;
   end
   assign d1_mem_rdata = d1_rd_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One transaction on the 2-cycle instance; starts at a negedge in IDLE
   task automatic txn(input string tag, input bit port, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
      int lat;
      lat = 0;
      if (port) begin
         dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
      end else begin
         cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk({tag, "_en"},   32'(mem_en), 32'd1);
            chk({tag, "_we"},   32'(mem_we), 32'(we));
            chk({tag, "_addr"}, mem_addr, addr);
            if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
         end
         chk({tag, "_other_rdy"}, 32'(port ? cpu_ready : dma_ready), 32'd0);
         if (port ? dma_ready : cpu_ready) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      cpu_req = 1'b0;
      dma_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [9:0]  order;
      logic [9:0]  exp_order;
      int          n_rdy, n_en, lat;
      int          en_cyc [0:3];

      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
      d1_cpu_req = 0; d1_cpu_we = 0; d1_cpu_addr = 0; d1_cpu_wdata = 0;
      d1_dma_req = 0; d1_dma_we = 0; d1_dma_addr = 0; d1_dma_wdata = 0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_mem_en",    32'(mem_en),    32'd0);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
      chk("rst_mem_addr",  mem_addr,       32'd0);
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rst_dma_ready", 32'(dma_ready), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata,      32'd0);
      chk("rst_dma_rdata", dma_rdata,      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-requester reads and writes
      txn("cpu_rd", 1'b0, 1'b0, 32'h10, 32'h0, 4);
      chk("cpu_rd_data", cpu_rdata, 32'hDEAD_BEEF);
      chk("cpu_rd_dma_data", dma_rdata, 32'h0);
      txn("cpu_wr", 1'b0, 1'b1, 32'h20, 32'h1234, 2);
      chk("cpu_wr_keep", cpu_rdata, 32'hDEAD_BEEF);
      txn("cpu_rd2", 1'b0, 1'b0, 32'h20, 32'h0, 4);
      chk("cpu_rd2_data", cpu_rdata, 32'h1234);
      txn("dma_rd", 1'b1, 1'b0, 32'h30, 32'h0, 4);
      chk("dma_rd_data", dma_rdata, 32'hCAFE_F00D);
      chk("dma_rd_cpu_keep", cpu_rdata, 32'h1234);
      txn("dma_wr", 1'b1, 1'b1, 32'h34, 32'h55, 2);
      chk("dma_wr_keep", dma_rdata, 32'hCAFE_F00D);

      // Both requesting continuously: CPU x4 then DMA, repeating
      order = '0; n_rdy = 0;
      exp_order = 10'b10_0001_0000;
      cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1'b1;
      dma_we = 0; dma_addr = 32'h30; dma_req = 1'b1;
      for (int c = 0; c < 80 && n_rdy < 10; c++) begin
         @(negedge clk);
         if (cpu_ready && dma_ready) chk("both_rdy", 32'd1, 32'd0);
         if (cpu_ready || dma_ready) begin
            order[n_rdy] = dma_ready;
            n_rdy++;
         end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      @(negedge clk);
      chk("arb_count", 32'(n_rdy), 32'd10);
      for (int i = 0; i < 10; i++) chk($sformatf("arb_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
      chk("arb_cpu_data", cpu_rdata, 32'hDEAD_BEEF);
      chk("arb_dma_data", dma_rdata, 32'hCAFE_F00D);

      // Back-to-back CPU reads with req held through ready
      n_rdy = 0; n_en = 0;
      cpu_we = 0; cpu_addr = 32'h0; cpu_req = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (mem_en && n_en < 4) begin
            en_cyc[n_en] = c;
            n_en++;
         end
         if (cpu_ready) begin
            n_rdy++;
            if (n_rdy == 1) begin
               chk("b2b_data0", cpu_rdata, 32'h1111_1111);
               cpu_addr = 32'h4;
            end else begin
               chk("b2b_data1", cpu_rdata, 32'h2222_2222);
               break;
            end
         end
      end
      cpu_req = 1'b0;
      @(negedge clk);
      chk("b2b_en_cnt", 32'(n_en), 32'd2);
      if (n_en >= 2) chk("b2b_en_gap", 32'(en_cyc[1] - en_cyc[0]), 32'd5);

      // MEM_LAT=1 build: DMA read ready at T+3
      lat = 0;
      d1_dma_we = 0; d1_dma_addr = 32'h8; d1_dma_req = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) chk("lat1_en", 32'(d1_mem_en), 32'd1);
         if (d1_dma_ready) begin
            lat = k;
            break;
         end
      end
      d1_dma_req = 1'b0;
      chk("lat1_lat",  32'(lat), 32'd3);
      chk("lat1_data", d1_dma_rdata, 32'h5A5A_0008);
      chk("lat1_cpu_rdy", 32'(d1_cpu_ready), 32'd0);
      @(negedge clk);

      // Reset during WAIT of a CPU read
      cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1'b1;
      @(negedge clk);   // ISSUE
      @(negedge clk);   // WAIT
      rst_n = 1'b0; cpu_req = 1'b0;
      #1;
      chk("rstw_mem_en",    32'(mem_en),    32'd0);
      chk("rstw_cpu_ready", 32'(cpu_ready), 32'd0);
      chk("rstw_dma_ready", 32'(dma_ready), 32'd0);
      chk("rstw_cpu_rdata", cpu_rdata,      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rstw_no_cpu_rdy", 32'(cpu_ready), 32'd0);
         chk("rstw_no_en",      32'(mem_en),    32'd0);
      end

      // Reset during ISSUE: mem_en must drop without waiting for a clock
      cpu_we = 1; cpu_addr = 32'h24; cpu_wdata = 32'h77; cpu_req = 1'b1;
      @(negedge clk);
      chk("rsti_en_before", 32'(mem_en), 32'd1);
      rst_n = 1'b0; cpu_req = 1'b0;
      #1;
      chk("rsti_mem_en", 32'(mem_en), 32'd0);
      chk("rsti_mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fresh request after reset completes with normal latency
      txn("post_rst", 1'b0, 1'b0, 32'h10, 32'h0, 4);
      chk("post_rst_data", cpu_rdata, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multi-cycle CPU between two requesters:
  - the CPU memory interface (fetch and lw/sw, selected by IorD upstream);
  - a DMA/debug loader port.
- Sequences each access as issue, then a fixed memory latency, then a one-cycle response.
- Sits between the CPU datapath and the memory model.
- The CPU has priority; a starvation counter bounds DMA waiting.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from issue cycle to mem_rdata valid (legal range 1..15)
STARVE_MAX, 4, consecutive CPU grants while DMA pending before DMA is forced (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_ready
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ready on reads
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  DMA request fields, same rules as CPU
dma_ready, dma_rdata  out  1/DATA_W  DMA completion pulse and read data
mem_en  out  1  memory access strobe, high exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - grant register 0 (CPU);
  - starvation counter 0;
  - latency counter 0;
  - rdata registers 0.
- Reset mid-transaction abandons the access. No ready pulse is produced for it, and mem_en drops immediately.
- States:
  - IDLE: no outputs active. If any req is sampled high, latch the winner's we/addr/wdata and grant, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_en=1; mem_we/addr/wdata come from the latched fields.
    - Write: go to RESP.
    - Read: load the latency counter with MEM_LAT-1. If MEM_LAT==1, go to CAPT; otherwise go to WAIT.
  - WAIT: decrement the counter; at 0, go to CAPT.
  - CAPT: the cycle in which mem_rdata is valid. Register mem_rdata into the granted requester's rdata register, then go to RESP.
  - RESP: the granted requester's ready=1 for exactly one cycle. Next state is IDLE.
- Latency:
  - req sampled in IDLE at cycle T → mem_en at T+1.
  - Write: ready at T+2.
  - Read: ready at T+2+MEM_LAT (T+4 at default).
- rdata:
  - Each requester's rdata holds its last read value until that requester's next read capture.
  - Writes do not change rdata.
- Arbitration (decided in IDLE only):
  - Only one requester high: that requester wins.
  - Both high: CPU wins, unless starve_cnt==STARVE_MAX, in which case DMA wins.
  - starve_cnt increments on each CPU grant made while dma_req=1, saturating at STARVE_MAX.
  - starve_cnt clears on any DMA grant, or on any IDLE cycle with dma_req=0.
- Handshake:
  - The requester holds req and its fields stable until it samples ready.
  - It may deassert req or raise it again (back-to-back) in the cycle after ready.
  - The loser's request stays pending. It is never dropped and gets no ready pulse.
- Protocol violation: if a granted requester drops req before ready, the access still completes and ready still pulses. Request fields are not re-sampled after IDLE.
- Throughput: minimum 3 cycles per write and 3+MEM_LAT cycles per read, because one IDLE cycle separates transactions.
- Address width: addresses pass through unmodified. No address decoding or wrap handling is done in this block.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE/ISSUE/WAIT/CAPT/RESP (3-bit);
  - grant constants GNT_CPU=0, GNT_DMA=1;
  - latency and starvation counter width (4 bits).
- One sub-module, arb_priority_sel:
  - combinational winner select from cpu_req, dma_req and starve_cnt;
  - plus the registered saturating starvation counter.
- The FSM, latches and rdata registers stay in the top module.

Test Plan:
- CPU read only: cpu_req=1, cpu_we=0, addr=0x10, memory returns 0xDEADBEEF. Required: mem_en at T+1 with addr 0x10 and mem_we=0; cpu_ready at T+4; cpu_rdata=0xDEADBEEF; dma_ready never pulses.
- CPU write: cpu_we=1, addr=0x20, wdata=0x1234. Required: mem_en=mem_we=1 at T+1 with addr 0x20 and wdata 0x1234; cpu_ready at T+2; cpu_rdata unchanged.
- Simultaneous requests: cpu_req and dma_req both held high continuously, all reads. Required: grant order CPU×4 then DMA, then CPU×4 then DMA again. dma_ready is never more than 5 transactions apart.
- DMA read with MEM_LAT=1 build: required ready at T+3, with data captured in the CAPT cycle.
- Reset mid-read: rst_n low during WAIT. Required: mem_en, cpu_ready and dma_ready all 0 immediately; no ready pulse after release; a fresh request then completes with normal latency.
- Back-to-back CPU reads at addrs 0x0 and 0x4, req kept high through ready. Required: two mem_en pulses 5 cycles apart; each cpu_ready carries the matching data.
